// File: rtl/router_output_channel.sv
// router_output_channel: two-VC transmit buffer for the router-to-router link.
// Even/odd phase: the crossbar writes one VC while the link drains the other.
`default_nettype none

module router_output_channel #(
    parameter int DATA_WIDTH = 64,
    parameter int VC_DEPTH   = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       polarity,
    input  logic                       wr_en,
    input  logic [DATA_WIDTH-1:0]      data_in,
    output logic                       wr_ready,
    input  logic                       ready_in,
    input  logic                       blocked,
    output logic                       send,
    output logic [DATA_WIDTH-1:0]      data_out,
    output logic [$clog2(VC_DEPTH):0]  vc1_count,
    output logic [$clog2(VC_DEPTH):0]  vc2_count,
    output logic                       drop_err
);

    localparam int PTR_W = $clog2(VC_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(VC_DEPTH);

    logic [DATA_WIDTH-1:0] vc1_mem [VC_DEPTH];
    logic [DATA_WIDTH-1:0] vc2_mem [VC_DEPTH];
    logic [PTR_W-1:0]      vc1_wr_ptr, vc1_rd_ptr;
    logic [PTR_W-1:0]      vc2_wr_ptr, vc2_rd_ptr;

    logic                  wr_vc_full;
    logic [CNT_W-1:0]      tx_count;
    logic [DATA_WIDTH-1:0] tx_head;
    logic                  xmit;
    logic                  do_write;
    logic                  vc1_push, vc1_pop, vc2_push, vc2_pop;

    // polarity=0: write VC1 / transmit VC2; polarity=1: the reverse
    always_comb begin
        wr_vc_full = polarity ? (vc2_count == FULL_COUNT) : (vc1_count == FULL_COUNT);
        tx_count   = polarity ? vc1_count : vc2_count;
        tx_head    = polarity ? vc1_mem[vc1_rd_ptr] : vc2_mem[vc2_rd_ptr];
        wr_ready   = !wr_vc_full;
        do_write   = wr_en && wr_ready;
        xmit       = ready_in && !blocked && (tx_count != '0);
        vc1_push   = do_write && !polarity;
        vc2_push   = do_write && polarity;
        vc1_pop    = xmit && polarity;
        vc2_pop    = xmit && !polarity;
    end

    // Storage is not reset; pointers and counts alone define validity.
    always_ff @(posedge clk) begin
        if (vc1_push) vc1_mem[vc1_wr_ptr] <= data_in;
        if (vc2_push) vc2_mem[vc2_wr_ptr] <= data_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vc1_wr_ptr <= '0;
            vc1_rd_ptr <= '0;
            vc2_wr_ptr <= '0;
            vc2_rd_ptr <= '0;
            vc1_count  <= '0;
            vc2_count  <= '0;
            send       <= 1'b0;
            data_out   <= '0;
            drop_err   <= 1'b0;
        end else begin
            // Push and pop never hit the same VC in one cycle, so each count moves by at most one.
            if (vc1_push) begin
                vc1_wr_ptr <= vc1_wr_ptr + 1'b1;
                vc1_count  <= vc1_count + 1'b1;
            end
            if (vc1_pop) begin
                vc1_rd_ptr <= vc1_rd_ptr + 1'b1;
                vc1_count  <= vc1_count - 1'b1;
            end
            if (vc2_push) begin
                vc2_wr_ptr <= vc2_wr_ptr + 1'b1;
                vc2_count  <= vc2_count + 1'b1;
            end
            if (vc2_pop) begin
                vc2_rd_ptr <= vc2_rd_ptr + 1'b1;
                vc2_count  <= vc2_count - 1'b1;
            end
            send     <= xmit;
            data_out <= xmit ? tx_head : '0;
            drop_err <= wr_en && !wr_ready;
        end
    end

endmodule

`default_nettype wire

// File: doc/router_output_channel.md
Name: router_output_channel

Overview:
- Transmit side of the router-to-router link: buffers flits leaving the router and drives send/data_out into the neighbouring router's input channel.
- Two virtual channels (VC1 even, VC2 odd), each a small FIFO.
- Even/odd phase scheme: in a given cycle the crossbar writes one VC while the link transmits the other, so a VC is never written and read in the same cycle.
- Sits between the router's crossbar/arbiter and the physical link.

Parameters:
- DATA_WIDTH, 64, flit width in bits.
- VC_DEPTH, 2, entries per virtual channel; power of two, minimum 2.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- polarity  input  1  global phase bit; toggles every cycle.
- wr_en  input  1  crossbar presents a flit this cycle.
- data_in  input  DATA_WIDTH  flit from crossbar.
- wr_ready  output  1  combinational; the VC targeted by this cycle's write has space.
- ready_in  input  1  downstream input channel can accept a flit.
- blocked  input  1  link stall; suppresses transmission this cycle.
- send  output  1  registered; flit valid on data_out.
- data_out  output  DATA_WIDTH  registered flit to the link.
- vc1_count  output  log2(VC_DEPTH)+1  VC1 occupancy.
- vc2_count  output  log2(VC_DEPTH)+1  VC2 occupancy.
- drop_err  output  1  registered one-cycle pulse; a write was attempted into a full VC.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, named reset.
- Reset values:
  - send=0, data_out=0, drop_err=0.
  - Both counts 0; all read/write pointers 0.
  - FIFO storage contents need not be cleared.
- Phase mapping:
  - polarity=0: write targets VC1, transmit sources VC2.
  - polarity=1: write targets VC2, transmit sources VC1.
- Write path:
  - wr_ready = !full(write VC), where full means count==VC_DEPTH.
  - wr_ready does not depend on wr_en; it is a pure function of polarity and the counts.
  - At the clk edge, if wr_en && wr_ready: store data_in at the write pointer, advance the pointer modulo VC_DEPTH, and increment the count.
  - If wr_en && !wr_ready: the flit is discarded and drop_err=1 in the next cycle; storage and pointers are unchanged.
- Transmit path:
  - xmit = ready_in && !blocked && (count of transmit VC > 0).
  - At the clk edge, if xmit: data_out <= head of transmit VC, send <= 1, advance the read pointer, and decrement the count.
  - Otherwise: send <= 0, data_out <= 0.
  - data_out is all zero whenever send=0.
  - Latency: a flit written at edge N is eligible at the first later edge whose phase selects its VC for transmit (normally N+1), and appears on send/data_out after that edge.
- Per-VC ordering: FIFO order is preserved within each VC. There is no ordering guarantee between VC1 and VC2.
- Simultaneous events:
  - A write and a transmit in the same cycle always touch different VCs, so each count changes by at most 1 per cycle.
  - When blocked=1, writes still proceed if wr_ready=1; only transmission is suppressed.
- Boundaries:
  - Pointers wrap from VC_DEPTH-1 to 0.
  - A full VC keeps wr_ready low during its write phases until a transmit phase drains it.
  - If ready_in=0 indefinitely, both VCs fill to VC_DEPTH and stop; no overflow occurs without a drop_err pulse.
- Reset mid-operation: all buffered flits are discarded. send goes low at the reset edge and stays low while reset=1; wr_ready=1 in the first cycle after reset deasserts.
- No state machine beyond the per-VC FIFO counters and pointers. The transmit decision is purely combinational from phase, counts, ready_in and blocked.

Test Plan:
- Reset, then polarity toggling with wr_en=1 for one cycle at polarity=0, data_in=64'hA5A5_0000_0000_0001, ready_in=1 -> vc1_count goes 0->1; at the next edge (polarity=1) send=1, data_out=64'hA5A5_0000_0000_0001; vc1_count returns to 0.
- ready_in=0, write flits 1,2,3 into VC1 on successive polarity=0 cycles (VC_DEPTH=2) -> vc1_count saturates at 2; wr_ready=0 on the third write phase; drop_err pulses once; when ready_in=1 the flits go out in order 1 then 2, and 3 is never sent.
- Interleaved writes: VC1 gets 0x10, 0x11 and VC2 gets 0x20, 0x21 with ready_in=1 -> data_out alternates VC streams per phase; each VC's order is preserved (0x10 before 0x11, 0x20 before 0x21); send=0 in any cycle where the transmit VC is empty.
- blocked=1 for 4 cycles with both VCs non-empty and ready_in=1 -> send stays 0 and counts do not decrease; writes during those cycles still land; after blocked falls, transmission resumes in FIFO order.
- Pointer wrap: stream 6 flits through VC2 with ready_in=1 -> all 6 are received in order and the count never exceeds VC_DEPTH.
- Reset asserted while vc1_count=2 and send=1 -> at the reset edge send=0, data_out=0, both counts 0; the previously buffered flits are never transmitted after reset deasserts.
